// File: rtl/uart_rx_fifo.sv
// UART receive front-end: re-arms the upstream receiver and queues each received word in a FWFT FIFO.
// Optional sticky overflow flag compiled in with `define UART_RX_FIFO_OVF_EN.
module uart_rx_fifo #(
   parameter int BIT   = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [BIT-1:0]           rx_data,
   input  logic                     rx_data_ready,
   output logic                     rx_data_start,
   output logic [BIT-1:0]           dout,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     ovf,
   input  logic                     ovf_clr
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   typedef enum logic [1:0] {
      ARM      = 2'd0,
      WAIT_RDY = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            start_q, start_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            ovf_q, ovf_d;
   logic [BIT-1:0]  mem_q [DEPTH];

   logic            push;
   logic            pop;
   logic            full;
   logic            accept;
   logic            drop;

   always_comb begin
      state_d = state_q;
      start_d = 1'b0;
      push    = 1'b0;
      case (state_q)
         ARM: begin
            // Arm only once the receiver has dropped back to idle.
            if (en && !rx_data_ready) begin
               state_d = WAIT_RDY;
               start_d = 1'b1;
            end else begin
               state_d = ARM;
            end
         end
         WAIT_RDY: begin
            if (rx_data_ready) begin
               push    = 1'b1;
               state_d = WAIT_LOW;
            end else begin
               state_d = WAIT_RDY;
            end
         end
         WAIT_LOW: begin
            if (!rx_data_ready) begin
               state_d = ARM;
            end else begin
               state_d = WAIT_LOW;
            end
         end
         default: begin
            state_d = ARM;
         end
      endcase
   end

   always_comb begin
      full   = (level_q == LW'(DEPTH));
      pop    = (level_q != {LW{1'b0}}) && dout_ready;
      accept = push && (!full || pop);
      drop   = push && full && !pop;

      if (accept) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end else begin
         wr_ptr_d = wr_ptr_q;
      end

      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end

      case ({accept, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase

`ifdef UART_RX_FIFO_OVF_EN
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop) begin
         ovf_d = 1'b1;
      end else if (ovf_clr) begin
         ovf_d = 1'b0;
      end else begin
         ovf_d = ovf_q;
      end
`else
      ovf_d = 1'b0;
`endif
   end

`ifndef UART_RX_FIFO_OVF_EN
   logic unused_ovf_clr;
   assign unused_ovf_clr = ovf_clr ^ drop;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ARM;
         start_q  <= 1'b0;
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         level_q  <= {LW{1'b0}};
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         mem_q[wr_ptr_q] <= rx_data;
      end
   end

   assign rx_data_start = start_q;
   assign dout          = mem_q[rd_ptr_q];
   assign dout_valid    = (level_q != {LW{1'b0}});
   assign level         = level_q;
   assign ovf           = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: queue-based reference model, per-cycle compare, directed scenarios
// plus a randomized phase. Honors `define UART_RX_FIFO_OVF_EN for the overflow expectation.
module tb_uart_rx_fifo;

   localparam int BIT   = 8;
   localparam int DEPTH = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic          en = 1'b1;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_data_ready = 1'b0;
   logic          rx_data_start;
   logic [7:0]    dout;
   logic          dout_valid;
   logic          dout_ready = 1'b0;
   logic [3:0]    level;
   logic          ovf;
   logic          ovf_clr = 1'b0;

   int total = 0;
   int bad   = 0;

   uart_rx_fifo #(.BIT(BIT), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .en(en), .rx_data(rx_data), .rx_data_ready(rx_data_ready),
      .rx_data_start(rx_data_start), .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
      .level(level), .ovf(ovf), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a queue of stored words and the receiver handshake phase
   // (0 = waiting to arm, 1 = armed and awaiting a word, 2 = word taken, waiting for ready to fall).
   logic [7:0] m_q[$];
   int         m_phase = 0;
   bit         m_start = 1'b0;
   bit         m_ovf   = 1'b0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            m_q.delete();
            m_phase = 0;
            m_start = 1'b0;
            m_ovf   = 1'b0;
         end else begin
            bit pop, push, full, drop;
            pop  = (m_q.size() != 0) && dout_ready;
            push = (m_phase == 1) && rx_data_ready;
            full = (m_q.size() == DEPTH);
            drop = push && full && !pop;
            if (pop) void'(m_q.pop_front());
            if (push && !drop) m_q.push_back(rx_data);
            m_start = 1'b0;
            if (m_phase == 0) begin
               if (en && !rx_data_ready) begin
                  m_phase = 1;
                  m_start = 1'b1;
               end
            end else if (m_phase == 1) begin
               if (rx_data_ready) m_phase = 2;
            end else if (!rx_data_ready) begin
               m_phase = 0;
            end
`ifdef UART_RX_FIFO_OVF_EN
            if (drop) m_ovf = 1'b1;
            else if (ovf_clr) m_ovf = 1'b0;
`endif
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk);
         chk("dout_valid", dout_valid, (m_q.size() != 0));
         chk("level", level, m_q.size());
         chk("ovf", ovf, m_ovf);
         chk("rx_data_start", rx_data_start, m_start);
         if (m_q.size() != 0) chk("dout", dout, m_q[0]);
      end
   end

   bit         collect = 1'b0;
   logic [7:0] seen[$];
   initial begin
      forever begin
         @(negedge clk);
         if (collect && dout_valid && dout_ready) seen.push_back(dout);
      end
   end

   task automatic wait_arm();
      int n = 0;
      while (m_phase != 1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("arm_timeout", 32'd1, 32'd0);
   endtask

   task automatic send(input logic [7:0] b, input int hold);
      wait_arm();
      rx_data       = b;
      rx_data_ready = 1'b1;
      repeat (hold) @(negedge clk);
      rx_data_ready = 1'b0;
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int         pulses;
      logic [7:0] sent[$];
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // Arm pulse after reset release, then a single push from a long ready period.
      @(negedge clk);
      chk("arm_after_reset", rx_data_start, 1'b1);
      pulses = 0;
      repeat (5) begin
         @(negedge clk);
         if (rx_data_start) pulses++;
      end
      chk("no_extra_arm", pulses, 0);
      rx_data       = 8'hA5;
      rx_data_ready = 1'b1;
      @(negedge clk);
      chk("a5_valid", dout_valid, 1'b1);
      chk("a5_dout", dout, 8'hA5);
      chk("a5_level", level, 4'd1);
      repeat (9) @(negedge clk);
      rx_data_ready = 1'b0;
      chk("a5_single_push", level, 4'd1);
      chk("model_a5", m_q.size(), 1);
      dout_ready = 1'b1;
      @(negedge clk);
      dout_ready = 1'b0;
      chk("a5_drained", level, 4'd0);

      // Fill, overflow, drain in order.
      for (int i = 1; i <= 8; i++) send(8'(i), 1);
      chk("fill_level", level, 4'd8);
      send(8'h09, 1);
      chk("drop_level", level, 4'd8);
`ifdef UART_RX_FIFO_OVF_EN
      chk("ovf_set", ovf, 1'b1);
`else
      chk("ovf_tied", ovf, 1'b0);
`endif
      dout_ready = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("drain_order", dout, 32'(i));
         @(negedge clk);
      end
      dout_ready = 1'b0;
      chk("drain_level", level, 4'd0);
      ovf_clr = 1'b1;
      @(negedge clk);
      ovf_clr = 1'b0;
      chk("ovf_cleared", ovf, 1'b0);

      // Push into a full FIFO while popping in the same cycle.
      for (int i = 0; i < 8; i++) send(8'(8'h10 + i), 1);
      chk("refill_level", level, 4'd8);
      wait_arm();
      rx_data       = 8'h55;
      rx_data_ready = 1'b1;
      dout_ready    = 1'b1;
      @(negedge clk);
      rx_data_ready = 1'b0;
      chk("full_pushpop_level", level, 4'd8);
      chk("full_pushpop_head", dout, 8'h11);
      chk("full_pushpop_ovf", ovf, 1'b0);
      repeat (7) @(negedge clk);
      chk("late_55", dout, 8'h55);
      chk("late_55_level", level, 4'd1);
      @(negedge clk);

      // Back-to-back stream with the consumer always ready; pointers wrap.
      seen.delete();
      collect = 1'b1;
      for (int i = 0; i < 20; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         sent.push_back(b);
         send(b, 1 + int'($urandom_range(0, 2)));
      end
      repeat (4) @(negedge clk);
      collect = 1'b0;
      chk("stream_count", seen.size(), 20);
      for (int i = 0; i < 20 && i < seen.size(); i++) chk("stream_data", seen[i], sent[i]);

      // Enable low blocks re-arming but not an in-flight capture.
      en = 1'b0;
      rx_data       = 8'h3C;
      rx_data_ready = 1'b1;
      repeat (3) @(negedge clk);
      rx_data_ready = 1'b0;
      repeat (3) @(negedge clk);
      pulses = 0;
      repeat (1000) begin
         @(negedge clk);
         if (rx_data_start) pulses++;
      end
      chk("en_low_no_arm", pulses, 0);
      en = 1'b1;
      repeat (5) begin
         @(negedge clk);
         if (rx_data_start) pulses++;
      end
      chk("en_high_one_arm", pulses, 1);
      dout_ready = 1'b0;

      // Randomized traffic, including overflow and clear collisions.
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         en         = ($urandom_range(0, 7) != 0);
         rx_data    = 8'($urandom);
         dout_ready = ($urandom_range(0, 2) == 0);
         ovf_clr    = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 3) == 0) rx_data_ready = ~rx_data_ready;
      end
      en = 1'b1; rx_data_ready = 1'b0; dout_ready = 1'b0; ovf_clr = 1'b0;

      // Asynchronous reset while armed with three words stored.
      do_reset();
      for (int i = 0; i < 3; i++) send(8'(8'hC0 + i), 2);
      wait_arm();
      chk("pre_rst_level", level, 4'd3);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_level", level, 4'd0);
      chk("async_rst_valid", dout_valid, 1'b0);
      chk("async_rst_ovf", ovf, 1'b0);
      chk("async_rst_start", rx_data_start, 1'b0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (3) begin
         @(negedge clk);
         if (rx_data_start) pulses++;
      end
      chk("rearm_after_rst", pulses, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
